// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the SRAM request arbiter
//
// Purpose: FSM state encoding, port-owner codes, default widths and the
// active-low byte-enable patterns used by sram_req_arbiter and sram_arb_pick.
// Ports: none (package).
package mem_pkg;

  localparam int ADDR_W_DFLT = 24;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [3:0] BE_ALL_N  = 4'b0000;
  localparam logic [3:0] BE_NONE_N = 4'hF;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - winner selection between fetch and load/store ports
//
// Purpose: combinational choice of which port wins arbitration this cycle.
// Build option SRAM_ARB_RR_EN: round-robin on ties using a last-grant register
// (resets to fetch, so load/store wins the first tie). Without it, load/store
// has fixed priority and no register exists.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-low reset (round-robin only)
//   if_req_i      fetch request
//   ls_req_i      load/store request
//   take_i        arbitration is being accepted this cycle
//   winner_o      OWN_IF / OWN_LS
module sram_arb_pick
  import mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic ls_req_i,
  input  logic take_i,
  output logic winner_o
);

`ifdef SRAM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= OWN_IF;
    end else if (take_i) begin
      last_q <= winner_o;
    end
  end

  // On a tie the port that did not win last time goes next.
  always_comb begin
    winner_o = ls_req_i ? OWN_LS : OWN_IF;
    if (if_req_i && ls_req_i) begin
      winner_o = (last_q == OWN_IF) ? OWN_LS : OWN_IF;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = clk_i ^ rst_i ^ take_i ^ if_req_i;

  always_comb begin
    winner_o = ls_req_i ? OWN_LS : OWN_IF;
  end
`endif

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-port request arbiter in front of the SRAM controller
//
// Purpose: merges the instruction-fetch port (read only) and the load/store
// port onto the controller start/rw/addr/data handshake, one access in flight,
// and routes read data / write completion back to the owning port.
// Build option SRAM_ARB_RR_EN selects round-robin instead of load/store priority.
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-low reset
//   if_req_i/if_addr_i             fetch request; if_gnt_o, if_rvalid_o back
//   ls_req_i/ls_we_i/ls_addr_i/
//   ls_wdata_i/ls_be_n_i           load/store request; ls_gnt_o, ls_rvalid_o,
//                                  ls_wdone_o back
//   rdata_o                        registered read data
//   start_o/rw_o/addr_o/wdata_o/
//   be_n_o                         controller command (all registered)
//   rdata_i/r_ready_i/w_finish_i/
//   busy_i                         controller responses and status
module sram_req_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [3:0]        ls_be_n_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic              ls_wdone_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              start_o,
  output logic              rw_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        be_n_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              r_ready_i,
  input  logic              w_finish_i,
  input  logic              busy_i
);

  arb_state_e state_q, state_d;
  logic       owner_q;
  logic       winner;
  logic       accept;
  logic       done;

  assign accept = (state_q == IDLE) && (if_req_i || ls_req_i) && !busy_i;
  // Only the response matching the pending direction ends the access.
  assign done   = rw_o ? r_ready_i : w_finish_i;

  sram_arb_pick u_pick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .if_req_i (if_req_i),
    .ls_req_i (ls_req_i),
    .take_i   (accept),
    .winner_o (winner)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Start and grant are decoded from registered state only.
  always_comb begin
    start_o  = (state_q == ISSUE);
    if_gnt_o = (state_q == ISSUE) && (owner_q == OWN_IF);
    ls_gnt_o = (state_q == ISSUE) && (owner_q == OWN_LS);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q     <= OWN_IF;
      rw_o        <= 1'b1;
      addr_o      <= '0;
      wdata_o     <= '0;
      be_n_o      <= BE_NONE_N;
      rdata_o     <= '0;
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      ls_wdone_o  <= 1'b0;
    end else begin
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      ls_wdone_o  <= 1'b0;
      if (accept) begin
        owner_q <= winner;
        if (winner == OWN_LS) begin
          rw_o    <= ~ls_we_i;
          addr_o  <= ls_addr_i;
          wdata_o <= ls_wdata_i;
          be_n_o  <= ls_be_n_i;
        end else begin
          rw_o    <= 1'b1;
          addr_o  <= if_addr_i;
          wdata_o <= '0;
          be_n_o  <= BE_ALL_N;
        end
      end
      if ((state_q == WAIT) && done) begin
        if (rw_o) begin
          rdata_o <= rdata_i;
          if (owner_q == OWN_IF) begin
            if_rvalid_o <= 1'b1;
          end else begin
            ls_rvalid_o <= 1'b1;
          end
        end else begin
          ls_wdone_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - scoreboard bench for sram_req_arbiter
module tb_sram_req_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam logic P_IF = 1'b0;
  localparam logic P_LS = 1'b1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o;
  logic          ls_req_i, ls_we_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i;
  logic [3:0]    ls_be_n_i;
  logic          ls_gnt_o, ls_rvalid_o, ls_wdone_o;
  logic [DW-1:0] rdata_o;
  logic          start_o, rw_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [3:0]    be_n_o;
  logic [DW-1:0] rdata_i;
  logic          r_ready_i, w_finish_i, busy_i;

  always #5 clk = ~clk;

  sram_req_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_be_n_i(ls_be_n_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_wdone_o(ls_wdone_o),
    .rdata_o(rdata_o), .start_o(start_o), .rw_o(rw_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .be_n_o(be_n_o), .rdata_i(rdata_i), .r_ready_i(r_ready_i), .w_finish_i(w_finish_i),
    .busy_i(busy_i)
  );

  typedef struct {
    logic          own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be_n;
  } req_t;

  req_t if_drv_q[$], ls_drv_q[$], pend_if[$], pend_ls[$];
  req_t exp_issue_q[$], exp_cpl_q[$];
  int   due_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lat_lo = 1, lat_hi = 4;
  logic m_last = P_IF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // SRAM contents as seen by the bench: a fixed map from address to data.
  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    if (a == 24'h000010) return 32'hDEADBEEF;
    return {a[7:0], a} ^ 32'h5A5A0F0F;
  endfunction

  function automatic req_t mk_if(input logic [AW-1:0] a);
    req_t r;
    r.own = P_IF; r.we = 1'b0; r.addr = a; r.wdata = '0; r.be_n = 4'b0000;
    return r;
  endfunction

  function automatic req_t mk_ls(input logic we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [3:0] be);
    req_t r;
    r.own = P_LS; r.we = we; r.addr = a; r.wdata = d; r.be_n = be;
    return r;
  endfunction

  function automatic req_t rnd_ls();
    logic [31:0] a = $urandom();
    logic [31:0] b = $urandom();
    return mk_ls(1'($urandom_range(0, 1)), a[AW-1:0], $urandom(), b[3:0]);
  endfunction

  function automatic req_t rnd_if();
    logic [31:0] a = $urandom();
    return mk_if(a[AW-1:0]);
  endfunction

  // Hand the pending requests to the port drivers and predict service order:
  // every pending request stays raised until granted, so at each arbitration
  // both ports compete while both still have work.
  task automatic launch();
    int ni = pend_if.size();
    int nl = pend_ls.size();
    int gi = 0, gl = 0;
    foreach (pend_if[i]) if_drv_q.push_back(pend_if[i]);
    foreach (pend_ls[i]) ls_drv_q.push_back(pend_ls[i]);
    while (gi < ni || gl < nl) begin
      logic take_ls;
      if (gi < ni && gl < nl) begin
`ifdef SRAM_ARB_RR_EN
        take_ls = (m_last == P_IF);
`else
        take_ls = 1'b1;
`endif
      end else begin
        take_ls = (gl < nl);
      end
      if (take_ls) begin
        exp_issue_q.push_back(pend_ls[gl]); exp_cpl_q.push_back(pend_ls[gl]); gl++;
        m_last = P_LS;
      end else begin
        exp_issue_q.push_back(pend_if[gi]); exp_cpl_q.push_back(pend_if[gi]); gi++;
        m_last = P_IF;
      end
    end
    pend_if.delete();
    pend_ls.delete();
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_cpl_q.size() > 0 || exp_issue_q.size() > 0 ||
            if_drv_q.size() > 0 || ls_drv_q.size() > 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      chk({"timeout_", name}, 128'(t), 128'(0));
      exp_cpl_q.delete(); exp_issue_q.delete(); if_drv_q.delete(); ls_drv_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {start_o, rw_o, addr_o, wdata_o, be_n_o, if_gnt_o, ls_gnt_o,
               if_rvalid_o, ls_rvalid_o, ls_wdone_o, rdata_o},
              {1'b0, 1'b1, 24'h0, 32'h0, 4'hF, 5'b0, 32'h0});
  endtask

  // Port drivers: keep the head request raised until its grant is seen.
  initial begin
    if_req_i = 1'b0; if_addr_i = '0;
    forever begin
      @(negedge clk);
      if (if_req_i && if_gnt_o && if_drv_q.size() > 0) void'(if_drv_q.pop_front());
      if (if_drv_q.size() > 0) begin
        if_req_i = 1'b1; if_addr_i = if_drv_q[0].addr;
      end else begin
        if_req_i = 1'b0;
      end
    end
  end

  initial begin
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_be_n_i = 4'hF;
    forever begin
      @(negedge clk);
      if (ls_req_i && ls_gnt_o && ls_drv_q.size() > 0) void'(ls_drv_q.pop_front());
      if (ls_drv_q.size() > 0) begin
        ls_req_i = 1'b1; ls_we_i = ls_drv_q[0].we; ls_addr_i = ls_drv_q[0].addr;
        ls_wdata_i = ls_drv_q[0].wdata; ls_be_n_i = ls_drv_q[0].be_n;
      end else begin
        ls_req_i = 1'b0;
      end
    end
  end

  // Controller model: answers each start after a random latency, and throws in
  // responses that do not match the pending direction or arrive while idle.
  initial begin
    logic          cap_rw;
    logic [AW-1:0] cap_addr;
    int            lat, k;
    bit            abort;
    r_ready_i = 1'b0; w_finish_i = 1'b0; rdata_i = '0;
    forever begin
      @(negedge clk);
      r_ready_i = 1'b0; w_finish_i = 1'b0;
      if (rst_i && start_o) begin
        cap_rw = rw_o; cap_addr = addr_o;
        lat = $urandom_range(lat_lo, lat_hi);
        abort = 1'b0;
        k = 1;
        while (k < lat && !abort) begin
          @(negedge clk);
          r_ready_i = 1'b0; w_finish_i = 1'b0;
          if (!rst_i) abort = 1'b1;
          else if ($urandom_range(0, 2) == 0) begin
            if (cap_rw) w_finish_i = 1'b1;
            else begin r_ready_i = 1'b1; rdata_i = $urandom(); end
          end
          k++;
        end
        if (!abort) begin
          @(negedge clk);
          if (rst_i) begin
            chk("hold", {rw_o, addr_o}, {cap_rw, cap_addr});
            if (cap_rw) begin r_ready_i = 1'b1; rdata_i = rd_val(cap_addr); end
            else w_finish_i = 1'b1;
            due_q.push_back(cyc + 1);
          end
        end
      end else if (rst_i && $urandom_range(0, 5) == 0) begin
        r_ready_i = 1'b1; rdata_i = $urandom();
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues or completes.
  initial begin
    req_t        e;
    logic [2:0]  cpl, exp_k;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        if (start_o) begin
          if (exp_issue_q.size() == 0) begin
            chk("issue_unexpected", 128'(start_o), 128'(0));
          end else begin
            e = exp_issue_q.pop_front();
            chk("issue", {rw_o, addr_o, be_n_o, if_gnt_o, ls_gnt_o, e.we ? wdata_o : 32'h0},
                         {~e.we, e.addr, e.be_n, e.own == P_IF, e.own == P_LS,
                          e.we ? e.wdata : 32'h0});
          end
        end else begin
          chk("gnt_without_start", {if_gnt_o, ls_gnt_o}, 2'b00);
        end
        cpl = {if_rvalid_o, ls_rvalid_o, ls_wdone_o};
        if (cpl != 3'b000) begin
          if (exp_cpl_q.size() == 0) begin
            chk("cpl_unexpected", 128'(cpl), 128'(0));
          end else begin
            e = exp_cpl_q.pop_front();
            exp_k = e.we ? 3'b001 : ((e.own == P_IF) ? 3'b100 : 3'b010);
            chk("cpl", {cpl, e.we ? 32'h0 : rdata_o}, {exp_k, e.we ? 32'h0 : rd_val(e.addr)});
            if (due_q.size() == 0) chk("cpl_time_missing", 128'(cyc), 128'(0));
            else chk("cpl_time", 128'(cyc), 128'(due_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_i = 1'b0; busy_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_vals");
    @(posedge clk); #3 rst_i = 1'b1;

    // Fetch-only read, 3-cycle controller latency.
    lat_lo = 3; lat_hi = 3;
    @(posedge clk); #1;
    pend_if.push_back(mk_if(24'h000010));
    launch(); wait_done("fetch");

    // Single store.
    @(posedge clk); #1;
    pend_ls.push_back(mk_ls(1'b1, 24'h000020, 32'h12345678, 4'b1100));
    launch(); wait_done("store");

    // busy_i stalls arbitration for 5 cycles.
    lat_lo = 1; lat_hi = 4;
    @(posedge clk); #1;
    busy_i = 1'b1;
    pend_if.push_back(rnd_if());
    launch();
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(start_o | if_gnt_o | ls_gnt_o);
    end
    chk("busy_stall", 128'(n), 128'(0));
    busy_i = 1'b0;
    @(negedge clk);
    chk("busy_release", {start_o, if_gnt_o}, 2'b11);
    wait_done("busy");

    // Reset during WAIT of a read abandons it.
    lat_lo = 8; lat_hi = 8;
    @(posedge clk); #1;
    pend_if.push_back(rnd_if());
    launch();
    n = 0;
    while (exp_issue_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    chk("rst_issue_seen", 128'(exp_issue_q.size()), 128'(0));
    @(posedge clk); #3 rst_i = 1'b0;
    #1 chk_reset_vals("reset_mid_wait");
    exp_cpl_q.delete(); due_q.delete(); exp_issue_q.delete();
    m_last = P_IF;
    repeat (2) @(posedge clk);
    #3 rst_i = 1'b1;
    lat_lo = 1; lat_hi = 4;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      n += int'(if_rvalid_o | ls_rvalid_o | ls_wdone_o);
    end
    chk("rst_no_cpl", 128'(n), 128'(0));
    @(posedge clk); #1;
    pend_if.push_back(rnd_if());
    launch(); wait_done("post_reset_fetch");

    // Both ports compete, twice in a row.
    repeat (2) begin
      @(posedge clk); #1;
      pend_ls.push_back(rnd_ls()); pend_ls.push_back(rnd_ls());
      pend_if.push_back(rnd_if()); pend_if.push_back(rnd_if());
      launch(); wait_done("tie");
    end

    // Random rounds.
    repeat (40) begin
      int ki = $urandom_range(0, 2);
      int kl = $urandom_range(0, 2);
      int st = $urandom_range(0, 3);
      if (ki == 0 && kl == 0) kl = 1;
      @(posedge clk); #1;
      busy_i = (st != 0);
      for (int i = 0; i < ki; i++) pend_if.push_back(rnd_if());
      for (int i = 0; i < kl; i++) pend_ls.push_back(rnd_ls());
      launch();
      repeat (st) @(negedge clk);
      busy_i = 1'b0;
      wait_done("random");
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-port request arbiter sitting directly upstream of the SRAM controller. It merges the CPU instruction-fetch port (read-only) and the load/store port (read/write, byte enables) onto the controller's single start/rw/addr/data handshake. It returns the read data or write completion to the port that owns the in-flight access. Only one access is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 24, request address width (matches controller addr_i)
- DATA_W, 32, data width

Ports:
- clk_i  in  1  single clock, all logic rising-edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  one-cycle accept pulse for the fetch port
- if_rvalid_o  out  1  one-cycle pulse; rdata_o valid for fetch
- ls_req_i  in  1  load/store request; held until ls_gnt_o
- ls_we_i  in  1  1 = write, 0 = read
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  DATA_W  write data
- ls_be_n_i  in  4  byte enables, active-low
- ls_gnt_o  out  1  one-cycle accept pulse for the load/store port
- ls_rvalid_o  out  1  one-cycle pulse; rdata_o valid for load
- ls_wdone_o  out  1  one-cycle pulse; store complete
- rdata_o  out  DATA_W  registered read data, held until the next read completes
- start_o  out  1  one-cycle start pulse to the controller
- rw_o  out  1  1 = read, 0 = write
- addr_o  out  ADDR_W  controller address
- wdata_o  out  DATA_W  controller write data
- be_n_o  out  4  controller byte enables
- rdata_i  in  DATA_W  controller read data
- r_ready_i  in  1  controller read data ready
- w_finish_i  in  1  controller write finished
- busy_i  in  1  controller busy

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if either request is high and busy_i is low, pick a winner and latch its address/wdata/be_n/we into the outputs. Latch owner. Go to ISSUE.
- Fetch latches rw_o=1 and be_n_o=4'b0000. Load/store latches rw_o=!ls_we_i.
- ISSUE: start_o=1 and the owner's gnt=1 for this one cycle. Go to WAIT.
- WAIT: addr/wdata/be_n/rw are held stable.
  - Read: on r_ready_i, capture rdata_i into rdata_o, pulse the owner's rvalid next cycle, go to IDLE.
  - Write: on w_finish_i, pulse ls_wdone_o next cycle, go to IDLE.
- Controller outputs not matching the pending direction are ignored. r_ready_i/w_finish_i outside WAIT are ignored.
- A request dropped before its gnt is simply not served. No queueing.
- Default pick: load/store has fixed priority over fetch.
- Reset values: start_o=0, rw_o=1, addr_o=0, wdata_o=0, be_n_o=4'hF, all gnt/rvalid/wdone=0, rdata_o=0, state=IDLE.
- Reset mid-access abandons the transaction. No completion pulse is produced, and the requester must reissue.

## Timing
- Request sampled in IDLE at edge N → start_o and gnt high in cycle N+1.
- Completion sampled at edge M → rvalid/wdone high in cycle M+1, with the FSM already in IDLE.
- A new request may be sampled in that same cycle M+1 (back-to-back issue every 3 cycles minimum plus controller latency).
- busy_i high in IDLE stalls arbitration. No gnt is issued.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests, the port not granted last wins. The last-grant register resets to fetch, so load/store wins the first tie.
- Not defined: fixed priority, with load/store over fetch. The last-grant register is not instantiated.

## Structure
- Shared package mem_pkg: FSM state enum (IDLE/ISSUE/WAIT), owner constants OWN_IF=0/OWN_LS=1, ADDR_W/DATA_W defaults, BE_ALL_N=4'b0000, BE_NONE_N=4'hF.
- One sub-module, sram_arb_pick: combinational winner selection plus the optional last-grant register under SRAM_ARB_RR_EN.

## Test plan
- Fetch-only read, addr 24'h000010, controller returns 32'hDEADBEEF after 3 cycles → start_o one cycle with rw_o=1 and be_n_o=0, if_gnt_o one cycle, if_rvalid_o one cycle with rdata_o=32'hDEADBEEF.
- Store addr 24'h000020, data 32'h12345678, be_n 4'b1100 → rw_o=0, wdata_o/be_n_o match, ls_wdone_o one cycle after w_finish_i, if_rvalid_o never pulses.
- Both ports request in the same cycle, two times in a row:
  - Fixed-priority build → ls served twice before fetch.
  - SRAM_ARB_RR_EN build → ls then if alternate.
- busy_i high for 5 cycles with if_req_i high → no start_o/gnt until the cycle after busy_i falls.
- Reset asserted during WAIT of a read → all outputs return to reset values immediately, no rvalid. After release, a new fetch completes normally.
- Spurious r_ready_i in IDLE and w_finish_i during a pending read → ignored, no pulses, read completes only on r_ready_i.
